// File: rtl/serial_tx.sv
// serial_tx: UART transmitter for a 32-bit stb/ack word stream; sends bits [7:0] of each word as 8N1.
// Define SERIAL_TX_PARITY_EN to insert an even parity bit before the stop bit (8E1).
module serial_tx #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_in,
    input  logic        input_in_stb,
    output logic        input_in_ack,
    output logic        tx,
    output logic        busy
);
    localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);

    generate
        if (CLOCKS_PER_BIT < 2) begin : g_bad_rate
            $error("serial_tx: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
        end
    endgenerate

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Only the low byte is ever transmitted.
    logic unused_upper;
    assign unused_upper = ^input_in[31:8];

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ack_d     = ack_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                ack_d     = 1'b1;
                cnt_d     = '0;
                bit_idx_d = '0;
                if (input_in_stb && ack_q) begin
                    shift_d = input_in[7:0];
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^input_in[7:0];
`endif
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    ack_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ack_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state: reset aborts any frame and parks the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    // Data byte is only meaningful after a handshake loads it.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign input_in_ack = ack_q;

endmodule
